alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: RF_AW, default 3, register-file address width (2**RF_AW 32-bit registers).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block accepts command this cycle.
REQ-006 cmd_fn  input  6  ALUFN code forwarded to ALU.
REQ-007 cmd_rd, cmd_ra, cmd_rb  input  RF_AW each  destination, operand-A, operand-B register indices.
REQ-008 cmd_imm_en  input  1  select cmd_imm instead of RF[cmd_rb] for operand B.
REQ-009 cmd_imm  input  32  immediate operand B.
REQ-010 alu_fn  output  6; alu_a, alu_b  output  32 each: drive downstream registered ALU (ALUFN, A, B).
REQ-011 alu_y  input  32  ALU registered result Y.
REQ-012 done  output  1  one-cycle completion pulse; done_rd  output  RF_AW; done_data  output  32.
REQ-013 dbg_addr  input  RF_AW; dbg_data  output  32: combinational RF read, RF[0] reads 0.
REQ-014 err  output  1  illegal-code flag (present only with ALU_ISSUE_ILLEGAL_EN).

Function
REQ-015 FSM states IDLE, ISSUE, CAPTURE, WB; transitions IDLE->ISSUE on accept, ISSUE->CAPTURE, CAPTURE->WB, WB->IDLE unconditionally.
REQ-016 cmd_ready = 1 only in IDLE; accept = cmd_valid & cmd_ready at rising edge.
REQ-017 On accept: latch cmd_fn, cmd_rd, operand A = RF[cmd_ra], operand B = cmd_imm_en ? cmd_imm : RF[cmd_rb]; index 0 reads 0.
REQ-018 alu_fn/alu_a/alu_b registered; hold latched values from ISSUE through WB; hold last values in IDLE.
REQ-019 ALU samples inputs at edge ending ISSUE; block samples alu_y at edge ending CAPTURE.
REQ-020 At edge ending CAPTURE: RF[rd] <= alu_y unless rd = 0 (write dropped); done_rd <= rd, done_data <= alu_y.
REQ-021 done = 1 exactly during WB; latency accept edge to done-high cycle = 3 cycles; max throughput one command per 4 cycles.
REQ-022 cmd_valid with cmd_ready = 0 is ignored; command fields need not be held by block.
REQ-023 No hazard logic: writeback precedes next accept, so back-to-back dependent commands read updated value.
REQ-024 done_rd/done_data retain last values outside WB.

Reset
REQ-025 rst overrides all: state <= IDLE, all RF entries <= 0, alu_fn/alu_a/alu_b <= 0, done <= 0, done_rd <= 0, done_data <= 0, err <= 0.
REQ-026 rst in any non-IDLE state aborts command: no RF write, no done pulse; cmd_ready = 1 in cycle after reset deasserts.

Configuration
REQ-027 Macro ALU_ISSUE_ILLEGAL_EN defined: legal codes 000011, 000101, 000111, 010000, 010001, 101000, 101110, 100110, 101001, 101010; illegal code accepted normally but no RF write, done still pulses in WB with done_data = 0, err = 1 during WB only.
REQ-028 Macro undefined: no err port, no code check; every code written back as alu_y.

Verification
REQ-029 Reset, dbg_addr 0..7 -> dbg_data 0; cmd_ready = 1.
REQ-030 imm 5 -> r1 (fn 010000, ra 0), then fn 010000 ra 1 rb 1 rd 2 -> done_data 10, done 3 cycles after accept, RF[2] = 10.
REQ-031 fn 010001, r1=5, imm 7, rd 3 -> RF[3] = 0xFFFFFFFE; fn 000101 A=5,B=7 -> 1.
REQ-032 cmd_valid held high continuously -> accepts every 4th cycle, cmd_ready low in ISSUE/CAPTURE/WB.
REQ-033 rd = 0 with fn 010000 imm 9 -> done_data 9, dbg_data(0) = 0; rst asserted in CAPTURE -> no done, target unchanged.
REQ-034 With macro, fn 111111 -> err = 1 and done = 1 in WB, done_data 0, RF unchanged; without macro -> RF written with alu_y.

Source files
------------

// File: rtl/alu_issue_if.sv
// Command, ALU and completion signal bundle for alu_issue.
// The slave modport is the issue block; the master modport is the
// surrounding environment (command source, downstream ALU, observer).
interface alu_issue_if #(
  parameter int RF_AW = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [5:0]       cmd_fn;
  logic [RF_AW-1:0] cmd_rd;
  logic [RF_AW-1:0] cmd_ra;
  logic [RF_AW-1:0] cmd_rb;
  logic             cmd_imm_en;
  logic [31:0]      cmd_imm;

  logic [5:0]       alu_fn;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [31:0]      alu_y;

  logic             done;
  logic [RF_AW-1:0] done_rd;
  logic [31:0]      done_data;

  logic [RF_AW-1:0] dbg_addr;
  logic [31:0]      dbg_data;

  modport slave (
    input  cmd_valid, cmd_fn, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    output cmd_ready,
    output alu_fn, alu_a, alu_b,
    input  alu_y,
    output done, done_rd, done_data,
    input  dbg_addr,
    output dbg_data
  );

  modport master (
    output cmd_valid, cmd_fn, cmd_rd, cmd_ra, cmd_rb, cmd_imm_en, cmd_imm,
    input  cmd_ready,
    input  alu_fn, alu_a, alu_b,
    output alu_y,
    input  done, done_rd, done_data,
    output dbg_addr,
    input  dbg_data
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: single-issue sequencer that reads operands from a small
// register file, drives a downstream registered ALU, and writes the result
// back. One command in flight; writeback completes before the next accept,
// so dependent commands need no hazard logic.
//
// Optional macro ALU_ISSUE_ILLEGAL_EN: adds the err output and an ALUFN
// legality check. Illegal codes complete normally but skip the RF write,
// report done_data = 0 and raise err for the WB cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | cmd_ready high; waiting for cmd_valid
// ISSUE   | operands on alu_*; ALU samples them at the end of this cycle
// CAPTURE | alu_y valid; result written back at the end of this cycle
// WB      | done pulse with done_rd/done_data
module alu_issue #(
  parameter int RF_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
`ifdef ALU_ISSUE_ILLEGAL_EN
  ,
  output logic        err
`endif
);

  localparam int NREG = 2 ** RF_AW;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WB} state_t;

  state_t           state;
  logic [31:0]      rf [NREG];
  logic [RF_AW-1:0] rd_q;
  logic             wr_ok;

  // Register 0 is hard-wired to zero on every read path.
  function automatic logic [31:0] rf_rd(input logic [RF_AW-1:0] a);
    return (a == '0) ? 32'd0 : rf[a];
  endfunction

  assign bus.cmd_ready = (state == IDLE);
  assign bus.dbg_data  = rf_rd(bus.dbg_addr);

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic illegal;

  // Classify the in-flight ALUFN; anything outside the legal set is illegal.
  always_comb begin
    illegal = 1'b1;
    case (bus.alu_fn)
      6'b000011, 6'b000101, 6'b000111, 6'b010000, 6'b010001,
      6'b101000, 6'b101110, 6'b100110, 6'b101001, 6'b101010: illegal = 1'b0;
      default: ;
    endcase
  end

  assign wr_ok = ~illegal;
`else
  assign wr_ok = 1'b1;
`endif

  // Sequencer, register file, ALU operand registers and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      rd_q          <= '0;
      bus.alu_fn    <= '0;
      bus.alu_a     <= '0;
      bus.alu_b     <= '0;
      bus.done      <= 1'b0;
      bus.done_rd   <= '0;
      bus.done_data <= '0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      err           <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
      err      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            rd_q       <= bus.cmd_rd;
            bus.alu_fn <= bus.cmd_fn;
            bus.alu_a  <= rf_rd(bus.cmd_ra);
            bus.alu_b  <= bus.cmd_imm_en ? bus.cmd_imm : rf_rd(bus.cmd_rb);
            state      <= ISSUE;
          end
        end
        ISSUE: state <= CAPTURE;
        CAPTURE: begin
          // Writes to register 0 are dropped; illegal codes never write.
          if (wr_ok && (rd_q != '0)) rf[rd_q] <= bus.alu_y;
          bus.done_rd   <= rd_q;
          bus.done_data <= wr_ok ? bus.alu_y : 32'd0;
          bus.done      <= 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_EN
          err           <= ~wr_ok;
`endif
          state         <= WB;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue. Models the downstream registered ALU
// and checks reset, arithmetic writeback, latency, back-to-back issue,
// register-0 handling, reset abort and the illegal-code path.
module tb_alu_issue;

  localparam logic [5:0] FN_ADD = 6'b010000;
  localparam logic [5:0] FN_SUB = 6'b010001;
  localparam logic [5:0] FN_LT  = 6'b000101;
  localparam logic [5:0] FN_BAD = 6'b111111;

  logic clk = 1'b0;
  logic rst;
  logic err_w;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_if #(.RF_AW(3)) bus ();

`ifdef ALU_ISSUE_ILLEGAL_EN
  alu_issue #(.RF_AW(3)) dut (.clk(clk), .rst(rst), .bus(bus), .err(err_w));
`else
  alu_issue #(.RF_AW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign err_w = 1'b0;
`endif

  // Downstream registered ALU: unknown codes give a + b + 0x100.
  function automatic logic [31:0] alu_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    case (fn)
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_LT:   return {31'd0, ($signed(a) < $signed(b))};
      default: return a + b + 32'h100;
    endcase
  endfunction

  always @(posedge clk) bus.alu_y <= alu_model(bus.alu_fn, bus.alu_a, bus.alu_b);

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Issue one command and wait for done; returns latency in cycles after accept.
  task automatic run_cmd(input logic [5:0] fn, input logic [2:0] rd, input logic [2:0] ra,
                         input logic [2:0] rb, input logic imm_en, input logic [31:0] imm,
                         output int lat, output logic [31:0] data, output logic [2:0] drd,
                         output logic errv);
    wait_ready();
    bus.cmd_fn     = fn;
    bus.cmd_rd     = rd;
    bus.cmd_ra     = ra;
    bus.cmd_rb     = rb;
    bus.cmd_imm_en = imm_en;
    bus.cmd_imm    = imm;
    bus.cmd_valid  = 1'b1;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    lat = 1;
    while (!bus.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    data = bus.done_data;
    drd  = bus.done_rd;
    errv = err_w;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.done_data !== 32'd0) begin failures++; $display("FAIL reset_done_data got=%h exp=0", bus.done_data); end
    checks++; if (bus.done_rd !== 3'd0) begin failures++; $display("FAIL reset_done_rd got=%0d exp=0", bus.done_rd); end
    checks++; if ({bus.alu_fn, bus.alu_a, bus.alu_b} !== 70'd0) begin failures++; $display("FAIL reset_alu got=%h exp=0", {bus.alu_fn, bus.alu_a, bus.alu_b}); end
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      checks++; if (bus.dbg_data !== 32'd0) begin failures++; $display("FAIL reset_rf%0d got=%h exp=0", i, bus.dbg_data); end
    end
  endtask

  task automatic test_add();
    int lat; logic [31:0] d; logic [2:0] r; logic e;
    run_cmd(FN_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, lat, d, r, e);
    checks++; if (lat !== 3) begin failures++; $display("FAIL add_imm_latency got=%0d exp=3", lat); end
    checks++; if (d !== 32'd5) begin failures++; $display("FAIL add_imm_data got=%h exp=5", d); end
    checks++; if (r !== 3'd1) begin failures++; $display("FAIL add_imm_rd got=%0d exp=1", r); end
    run_cmd(FN_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 32'd0, lat, d, r, e);
    checks++; if (lat !== 3) begin failures++; $display("FAIL add_rr_latency got=%0d exp=3", lat); end
    checks++; if (d !== 32'd10) begin failures++; $display("FAIL add_rr_data got=%h exp=a", d); end
    checks++; if ({bus.alu_fn, bus.alu_a, bus.alu_b} !== {FN_ADD, 32'd5, 32'd5}) begin failures++; $display("FAIL add_alu_hold got=%h exp=%h", {bus.alu_fn, bus.alu_a, bus.alu_b}, {FN_ADD, 32'd5, 32'd5}); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL add_done_pulse got=%b exp=0", bus.done); end
    checks++; if (bus.done_data !== 32'd10) begin failures++; $display("FAIL add_done_retain got=%h exp=a", bus.done_data); end
    bus.dbg_addr = 3'd2;
    #1;
    checks++; if (bus.dbg_data !== 32'd10) begin failures++; $display("FAIL add_rf2 got=%h exp=a", bus.dbg_data); end
  endtask

  task automatic test_sub_lt();
    int lat; logic [31:0] d; logic [2:0] r; logic e;
    run_cmd(FN_SUB, 3'd3, 3'd1, 3'd0, 1'b1, 32'd7, lat, d, r, e);
    checks++; if (d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_data got=%h exp=fffffffe", d); end
    bus.dbg_addr = 3'd3;
    #1;
    checks++; if (bus.dbg_data !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_rf3 got=%h exp=fffffffe", bus.dbg_data); end
    run_cmd(FN_LT, 3'd4, 3'd1, 3'd0, 1'b1, 32'd7, lat, d, r, e);
    checks++; if (d !== 32'd1) begin failures++; $display("FAIL lt_data got=%h exp=1", d); end
    @(negedge clk);
    checks++; if ({bus.alu_fn, bus.alu_a, bus.alu_b} !== {FN_LT, 32'd5, 32'd7}) begin failures++; $display("FAIL idle_alu_hold got=%h exp=%h", {bus.alu_fn, bus.alu_a, bus.alu_b}, {FN_LT, 32'd5, 32'd7}); end
    bus.dbg_addr = 3'd4;
    #1;
    checks++; if (bus.dbg_data !== 32'd1) begin failures++; $display("FAIL lt_rf4 got=%h exp=1", bus.dbg_data); end
  endtask

  // r6 <= r6 + 1 issued with cmd_valid held high: dependent chain 1, 2, 3.
  task automatic test_back_to_back();
    wait_ready();
    bus.cmd_fn     = FN_ADD;
    bus.cmd_rd     = 3'd6;
    bus.cmd_ra     = 3'd6;
    bus.cmd_rb     = 3'd0;
    bus.cmd_imm_en = 1'b1;
    bus.cmd_imm    = 32'd1;
    bus.cmd_valid  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 11) bus.cmd_valid = 1'b0;
      checks++; if (bus.cmd_ready !== ((k % 4) == 0)) begin failures++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, bus.cmd_ready, ((k % 4) == 0)); end
      checks++; if (bus.done !== ((k % 4) == 3)) begin failures++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, bus.done, ((k % 4) == 3)); end
      if ((k % 4) == 3) begin
        checks++; if (bus.done_data !== 32'(k / 4 + 1)) begin failures++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, bus.done_data, 32'(k / 4 + 1)); end
      end
    end
    @(negedge clk);
    bus.dbg_addr = 3'd6;
    #1;
    checks++; if (bus.dbg_data !== 32'd3) begin failures++; $display("FAIL b2b_rf6 got=%h exp=3", bus.dbg_data); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_final_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_rd0();
    int lat; logic [31:0] d; logic [2:0] r; logic e;
    run_cmd(FN_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 32'd9, lat, d, r, e);
    checks++; if (d !== 32'd9) begin failures++; $display("FAIL rd0_data got=%h exp=9", d); end
    checks++; if (r !== 3'd0) begin failures++; $display("FAIL rd0_rd got=%0d exp=0", r); end
    bus.dbg_addr = 3'd0;
    #1;
    checks++; if (bus.dbg_data !== 32'd0) begin failures++; $display("FAIL rd0_rf0 got=%h exp=0", bus.dbg_data); end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    wait_ready();
    bus.cmd_fn     = FN_ADD;
    bus.cmd_rd     = 3'd7;
    bus.cmd_ra     = 3'd0;
    bus.cmd_imm_en = 1'b1;
    bus.cmd_imm    = 32'd42;
    bus.cmd_valid  = 1'b1;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (bus.done) seen++;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", bus.cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    bus.dbg_addr = 3'd7;
    #1;
    checks++; if (bus.dbg_data !== 32'd0) begin failures++; $display("FAIL abort_rf7 got=%h exp=0", bus.dbg_data); end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] d; logic [2:0] r; logic e;
    run_cmd(FN_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5, lat, d, r, e);
    run_cmd(FN_BAD, 3'd5, 3'd1, 3'd0, 1'b1, 32'd3, lat, d, r, e);
    checks++; if (lat !== 3) begin failures++; $display("FAIL bad_latency got=%0d exp=3", lat); end
`ifdef ALU_ISSUE_ILLEGAL_EN
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL bad_data got=%h exp=0", d); end
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL bad_err got=%b exp=1", e); end
    @(negedge clk);
    checks++; if (err_w !== 1'b0) begin failures++; $display("FAIL bad_err_clear got=%b exp=0", err_w); end
    bus.dbg_addr = 3'd5;
    #1;
    checks++; if (bus.dbg_data !== 32'd0) begin failures++; $display("FAIL bad_rf5 got=%h exp=0", bus.dbg_data); end
`else
    checks++; if (d !== 32'h108) begin failures++; $display("FAIL bad_data got=%h exp=108", d); end
    bus.dbg_addr = 3'd5;
    #1;
    checks++; if (bus.dbg_data !== 32'h108) begin failures++; $display("FAIL bad_rf5 got=%h exp=108", bus.dbg_data); end
`endif
  endtask

  initial begin
    rst            = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_fn     = '0;
    bus.cmd_rd     = '0;
    bus.cmd_ra     = '0;
    bus.cmd_rb     = '0;
    bus.cmd_imm_en = 1'b0;
    bus.cmd_imm    = '0;
    bus.dbg_addr   = '0;
    test_reset();
    test_add();
    test_sub_lt();
    test_back_to_back();
    test_rd0();
    test_reset_abort();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
